dmem_arbiter: RTL and testbench

Shares the single data memory between the CPU MEM stage and a DMA/loader requester. The memory has one read port and one write port, and the read port has one-cycle latency. The CPU has priority on each port independently. A DMA burst is sequenced beat by beat into whichever port the CPU leaves free. A starvation counter stalls the CPU for one cycle so that a blocked DMA beat can complete. The block sits between the MEM stage and DMEM, replacing the MEM stage's direct DMEM wiring.

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and a DMA
// burst requester. The CPU owns each port by default; DMA beats slip into
// whichever port the CPU leaves idle, and a starvation counter forces a
// one-cycle CPU stall so a long-blocked beat can complete.
//
// state | meaning
// IDLE  | CPU pass-through on both ports, waiting for a DMA request
// BURST | DMA beats issued on the burst's port whenever allowed
// DONE  | one-cycle completion pulse, request not sampled
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int BURST_LEN_WIDTH = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_cpu_rd_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_cpu_rd_addr,
  input  logic                       in_cpu_wr_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_cpu_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_cpu_wr_word,
  output logic [DMEM_WORD_WIDTH-1:0] out_cpu_rd_word,
  output logic                       out_cpu_stall,
  input  logic                       in_dma_req,
  input  logic                       in_dma_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dma_addr,
  input  logic [BURST_LEN_WIDTH-1:0] in_dma_len,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dma_wr_word,
  output logic                       out_dma_gnt,
  output logic                       out_dma_rd_valid,
  output logic [DMEM_WORD_WIDTH-1:0] out_dma_rd_word,
  output logic                       out_dma_busy,
  output logic                       out_dma_done,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic                       out_mem_write_en,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word
);

  localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                     state, state_next;
  logic [DMEM_ADDR_WIDTH-1:0] base_addr;
  logic [BURST_LEN_WIDTH-1:0] burst_len;
  logic [BURST_LEN_WIDTH-1:0] beat_cnt;
  logic                       burst_we;
  logic [STARVE_WIDTH-1:0]    starve_cnt;
  logic                       rd_owner_dma;

  logic                       conflict;
  logic                       starve_hit;
  logic                       dma_gnt;
  logic                       cpu_stall;
  logic                       dma_wr_beat;
  logic                       dma_rd_beat;
  logic [DMEM_ADDR_WIDTH-1:0] beat_addr;

  // base + count wraps naturally at the top of memory
  assign beat_addr = base_addr + DMEM_ADDR_WIDTH'(beat_cnt);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus grant/stall decision from state and CPU enables
  always_comb begin
    state_next = state;
    conflict   = 1'b0;
    starve_hit = 1'b0;
    dma_gnt    = 1'b0;
    cpu_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (in_dma_req) state_next = BURST;
      end
      BURST: begin
        conflict   = burst_we ? in_cpu_wr_en : in_cpu_rd_en;
        starve_hit = (starve_cnt == STARVE_WIDTH'(STARVE_LIMIT));
        dma_gnt    = !conflict || starve_hit;
        cpu_stall  = conflict && starve_hit;
        if (dma_gnt && (beat_cnt == burst_len)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst context, beat/starve counters and the read-data owner flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_addr    <= '0;
      burst_len    <= '0;
      burst_we     <= 1'b0;
      beat_cnt     <= '0;
      starve_cnt   <= '0;
      rd_owner_dma <= 1'b0;
    end else begin
      rd_owner_dma <= dma_rd_beat;
      if (state == IDLE && in_dma_req) begin
        base_addr  <= in_dma_addr;
        burst_len  <= in_dma_len;
        burst_we   <= in_dma_we;
        beat_cnt   <= '0;
        starve_cnt <= '0;
      end else if (state == BURST) begin
        if (dma_gnt) begin
          beat_cnt   <= beat_cnt + BURST_LEN_WIDTH'(1);
          starve_cnt <= '0;
        end else begin
          starve_cnt <= starve_cnt + STARVE_WIDTH'(1);
        end
      end
    end
  end

  // Port muxes: a granted beat takes its port, otherwise CPU pass-through.
  // A forced stall also drops the CPU store on the other port.
  always_comb begin
    dma_wr_beat      = dma_gnt && burst_we;
    dma_rd_beat      = dma_gnt && !burst_we;
    out_mem_wr_addr  = dma_wr_beat ? beat_addr : in_cpu_wr_addr;
    out_mem_wr_word  = dma_wr_beat ? in_dma_wr_word : in_cpu_wr_word;
    out_mem_rd_addr  = dma_rd_beat ? beat_addr : in_cpu_rd_addr;
    out_mem_write_en = !reset && (dma_wr_beat || (in_cpu_wr_en && !cpu_stall));
  end

  assign out_dma_gnt      = dma_gnt;
  assign out_cpu_stall    = cpu_stall;
  assign out_dma_busy     = (state != IDLE);
  assign out_dma_done     = (state == DONE);
  assign out_dma_rd_valid = rd_owner_dma;
  assign out_dma_rd_word  = in_mem_rd_word;
  assign out_cpu_rd_word  = in_mem_rd_word;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios against a behavioural arbiter model and
// a simple 1-cycle-latency DMEM array.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int SL = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clr_mem = 1'b1;
  logic          in_cpu_rd_en = 1'b0;
  logic [AW-1:0] in_cpu_rd_addr = '0;
  logic          in_cpu_wr_en = 1'b0;
  logic [AW-1:0] in_cpu_wr_addr = '0;
  logic [DW-1:0] in_cpu_wr_word = '0;
  logic [DW-1:0] out_cpu_rd_word;
  logic          out_cpu_stall;
  logic          in_dma_req = 1'b0;
  logic          in_dma_we = 1'b0;
  logic [AW-1:0] in_dma_addr = '0;
  logic [LW-1:0] in_dma_len = '0;
  logic [DW-1:0] in_dma_wr_word = '0;
  logic          out_dma_gnt;
  logic          out_dma_rd_valid;
  logic [DW-1:0] out_dma_rd_word;
  logic          out_dma_busy;
  logic          out_dma_done;
  logic [AW-1:0] out_mem_rd_addr;
  logic [AW-1:0] out_mem_wr_addr;
  logic [DW-1:0] out_mem_wr_word;
  logic          out_mem_write_en;
  logic [DW-1:0] in_mem_rd_word;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(DW),
    .BURST_LEN_WIDTH(LW), .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock), .reset(reset),
    .in_cpu_rd_en(in_cpu_rd_en), .in_cpu_rd_addr(in_cpu_rd_addr),
    .in_cpu_wr_en(in_cpu_wr_en), .in_cpu_wr_addr(in_cpu_wr_addr),
    .in_cpu_wr_word(in_cpu_wr_word), .out_cpu_rd_word(out_cpu_rd_word),
    .out_cpu_stall(out_cpu_stall),
    .in_dma_req(in_dma_req), .in_dma_we(in_dma_we), .in_dma_addr(in_dma_addr),
    .in_dma_len(in_dma_len), .in_dma_wr_word(in_dma_wr_word),
    .out_dma_gnt(out_dma_gnt), .out_dma_rd_valid(out_dma_rd_valid),
    .out_dma_rd_word(out_dma_rd_word), .out_dma_busy(out_dma_busy),
    .out_dma_done(out_dma_done),
    .out_mem_rd_addr(out_mem_rd_addr), .out_mem_wr_addr(out_mem_wr_addr),
    .out_mem_wr_word(out_mem_wr_word), .out_mem_write_en(out_mem_write_en),
    .in_mem_rd_word(in_mem_rd_word)
  );

  // DMEM: one write port, one read port with a registered read
  logic [DW-1:0] dmem [0:4095];
  logic [DW-1:0] dmem_q;
  always @(posedge clock) begin
    if (reset && clr_mem) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= '0;
    end else if (out_mem_write_en) begin
      dmem[out_mem_wr_addr] <= out_mem_wr_word;
    end
    dmem_q <= dmem[out_mem_rd_addr];
  end
  assign in_mem_rd_word = dmem_q;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: burst progress as plain counts plus a golden memory
  logic          m_act = 1'b0;
  logic          m_donep = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_base = '0;
  int            m_len = 0;
  int            m_beats = 0;
  int            m_wait = 0;
  logic          m_rdv = 1'b0;
  logic [DW-1:0] m_rdv_word = '0;
  logic          m_cpu_rdp = 1'b0;
  logic [DW-1:0] m_cpu_rd_word = '0;
  logic [DW-1:0] gold [0:4095];

  function automatic logic conflict_now();
    return m_act && (m_we ? in_cpu_wr_en : in_cpu_rd_en);
  endfunction
  function automatic logic force_now();
    return conflict_now() && (m_wait == SL);
  endfunction
  function automatic logic gnt_now();
    return m_act && (!conflict_now() || (m_wait == SL));
  endfunction
  function automatic logic [AW-1:0] beat_addr();
    return AW'((int'(m_base) + m_beats) % (1 << AW));
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act     <= 1'b0;
      m_donep   <= 1'b0;
      m_rdv     <= 1'b0;
      m_cpu_rdp <= 1'b0;
      m_beats   <= 0;
      m_wait    <= 0;
      if (clr_mem) for (int i = 0; i < 4096; i++) gold[i] <= '0;
    end else begin
      m_rdv         <= gnt_now() && !m_we;
      m_rdv_word    <= gold[beat_addr()];
      m_cpu_rdp     <= in_cpu_rd_en && !force_now() && !(gnt_now() && !m_we);
      m_cpu_rd_word <= gold[in_cpu_rd_addr];
      if (in_cpu_wr_en && !force_now() && !(gnt_now() && m_we))
        gold[in_cpu_wr_addr] <= in_cpu_wr_word;
      if (gnt_now() && m_we) gold[beat_addr()] <= in_dma_wr_word;
      m_donep <= 1'b0;
      if (m_act) begin
        if (gnt_now()) begin
          m_beats <= m_beats + 1;
          m_wait  <= 0;
          if (m_beats == m_len) begin
            m_act   <= 1'b0;
            m_donep <= 1'b1;
          end
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (!m_donep && in_dma_req) begin
        m_act   <= 1'b1;
        m_base  <= in_dma_addr;
        m_len   <= int'(in_dma_len);
        m_we    <= in_dma_we;
        m_beats <= 0;
        m_wait  <= 0;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  logic          e_gnt, e_stall, e_we;
  logic [AW-1:0] e_wa, e_ra;
  logic [DW-1:0] e_ww;
  always @(negedge clock) begin
    e_gnt   = !reset && gnt_now();
    e_stall = !reset && force_now();
    e_wa    = (e_gnt && m_we) ? beat_addr() : in_cpu_wr_addr;
    e_ww    = (e_gnt && m_we) ? in_dma_wr_word : in_cpu_wr_word;
    e_ra    = (e_gnt && !m_we) ? beat_addr() : in_cpu_rd_addr;
    e_we    = !reset && ((e_gnt && m_we) || (in_cpu_wr_en && !e_stall));
    chk("gnt", 32'(out_dma_gnt), 32'(e_gnt));
    chk("stall", 32'(out_cpu_stall), 32'(e_stall));
    chk("write_en", 32'(out_mem_write_en), 32'(e_we));
    chk("wr_addr", 32'(out_mem_wr_addr), 32'(e_wa));
    chk("wr_word", 32'(out_mem_wr_word), 32'(e_ww));
    chk("rd_addr", 32'(out_mem_rd_addr), 32'(e_ra));
    chk("busy", 32'(out_dma_busy), 32'(m_act || m_donep));
    chk("done", 32'(out_dma_done), 32'(m_donep));
    chk("rd_valid", 32'(out_dma_rd_valid), 32'(m_rdv));
    if (m_rdv) chk("dma_rd_word", 32'(out_dma_rd_word), 32'(m_rdv_word));
    if (m_cpu_rdp) chk("cpu_rd_word", 32'(out_cpu_rd_word), 32'(m_cpu_rd_word));
  end

  // Stimulus bookkeeping
  int            stepno = 0;
  int            gnt_seen, done_seen, stall_seen, we_seen, rdv_seen;
  int            first_gnt, done_at, req_at;
  logic [DW-1:0] rdv_words [0:7];
  logic [DW-1:0] dbase = '0;

  task automatic clr();
    gnt_seen = 0; done_seen = 0; stall_seen = 0; we_seen = 0; rdv_seen = 0;
    first_gnt = -1; done_at = -1;
  endtask

  task automatic step();
    @(negedge clock);
    if (out_dma_gnt) begin
      if (first_gnt < 0) first_gnt = stepno;
      gnt_seen++;
    end
    if (out_dma_done) begin
      done_seen++;
      done_at = stepno;
    end
    if (out_cpu_stall) stall_seen++;
    if (out_mem_write_en) we_seen++;
    if (out_dma_rd_valid && rdv_seen < 8) begin
      rdv_words[rdv_seen] = out_dma_rd_word;
      rdv_seen++;
    end
    stepno++;
    @(posedge clock);
    #1;
    in_dma_wr_word = dbase + DW'(gnt_seen);
  endtask

  task automatic request(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    in_dma_req  = 1'b1;
    in_dma_we   = we;
    in_dma_addr = addr;
    in_dma_len  = len;
    req_at      = stepno;
    step();
    in_dma_req  = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && done_seen == 0; i++) step();
    chk("done_within_budget", 32'(done_seen), 32'd1);
  endtask

  int            n;
  int            s0;
  logic [AW-1:0] seed_addr;

  initial begin
    clr();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", 32'(out_dma_busy), 32'd0);
    chk("reset_write_en", 32'(out_mem_write_en), 32'd0);
    clr_mem = 1'b0;
    reset   = 1'b0;

    // idle pass-through: store then load
    clr();
    in_cpu_wr_en = 1'b1; in_cpu_wr_addr = 12'h0A5; in_cpu_wr_word = 16'h1234;
    step();
    in_cpu_wr_en = 1'b0; in_cpu_rd_en = 1'b1; in_cpu_rd_addr = 12'h0A5;
    step();
    in_cpu_rd_en = 1'b0;
    chk("idle_load_word", 32'(out_cpu_rd_word), 32'h1234);
    chk("idle_we_cycles", 32'(we_seen), 32'd1);
    chk("idle_stall", 32'(stall_seen), 32'd0);

    // uncontended write burst 0x010..0x013 <- 1..4
    clr(); dbase = 16'h1; in_dma_wr_word = 16'h1;
    request(1'b1, 12'h010, 4'd3);
    run_to_done(20);
    chk("wb_first_gnt", 32'(first_gnt - req_at), 32'd1);
    chk("wb_gnt_cycles", 32'(gnt_seen), 32'd4);
    chk("wb_done_at", 32'(done_at - req_at), 32'd5);
    for (int k = 0; k < 4; k++) chk("wb_mem", 32'(dmem[12'h010 + k]), 32'(k + 1));

    // read burst alongside continuous CPU stores
    clr();
    in_cpu_wr_en = 1'b1; in_cpu_wr_addr = 12'h200; in_cpu_wr_word = 16'h7000;
    request(1'b0, 12'h010, 4'd1);
    for (int i = 0; i < 20 && done_seen == 0; i++) begin
      in_cpu_wr_word = in_cpu_wr_word + 16'h1;
      step();
    end
    in_cpu_wr_en = 1'b0;
    chk("rb_done", 32'(done_seen), 32'd1);
    chk("rb_gnt_cycles", 32'(gnt_seen), 32'd2);
    chk("rb_back_to_back", 32'(done_at - first_gnt), 32'd2);
    chk("rb_rdv_count", 32'(rdv_seen), 32'd2);
    chk("rb_word0", 32'(rdv_words[0]), 32'h1);
    chk("rb_word1", 32'(rdv_words[1]), 32'h2);
    chk("rb_stall", 32'(stall_seen), 32'd0);

    // starvation: single write beat blocked by CPU stores
    clr(); dbase = 16'hBEEF; in_dma_wr_word = 16'hBEEF; n = 0;
    in_cpu_wr_en = 1'b1; in_cpu_wr_addr = 12'h301; in_cpu_wr_word = 16'h5000;
    in_dma_req = 1'b1; in_dma_we = 1'b1; in_dma_addr = 12'h300; in_dma_len = 4'd0;
    req_at = stepno;
    for (int i = 0; i < 12; i++) begin
      s0 = stall_seen;
      step();
      in_dma_req = 1'b0;
      if (stall_seen == s0) n++;
      in_cpu_wr_word = 16'h5000 + DW'(n);
    end
    in_cpu_wr_en = 1'b0;
    step();
    chk("sv_first_gnt", 32'(first_gnt - req_at), 32'd9);
    chk("sv_stall_count", 32'(stall_seen), 32'd1);
    chk("sv_gnt_count", 32'(gnt_seen), 32'd1);
    chk("sv_done", 32'(done_seen), 32'd1);
    chk("sv_dma_word", 32'(dmem[12'h300]), 32'hBEEF);
    chk("sv_cpu_word", 32'(dmem[12'h301]), 32'h500A);

    // address wrap on a read burst
    for (int k = 0; k < 4; k++) begin
      seed_addr = 12'hFFE + AW'(k);
      in_cpu_wr_en = 1'b1; in_cpu_wr_addr = seed_addr; in_cpu_wr_word = 16'hA1 + DW'(k);
      step();
    end
    in_cpu_wr_en = 1'b0;
    clr();
    request(1'b0, 12'hFFE, 4'd3);
    run_to_done(20);
    chk("wrap_rdv_count", 32'(rdv_seen), 32'd4);
    for (int k = 0; k < 4; k++) chk("wrap_word", 32'(rdv_words[k]), 32'hA1 + 32'(k));

    // reset in the middle of a long write burst
    clr(); dbase = 16'h70; in_dma_wr_word = 16'h70;
    request(1'b1, 12'h400, 4'd7);
    for (int i = 0; i < 20 && gnt_seen < 2; i++) step();
    chk("mr_two_beats", 32'(gnt_seen), 32'd2);
    #1;
    reset = 1'b1;
    in_cpu_wr_en = 1'b1; in_cpu_wr_addr = 12'h4F0; in_cpu_wr_word = 16'hDEAD;
    #1;
    chk("mr_busy", 32'(out_dma_busy), 32'd0);
    chk("mr_gnt", 32'(out_dma_gnt), 32'd0);
    chk("mr_write_en", 32'(out_mem_write_en), 32'd0);
    chk("mr_wr_addr_passthru", 32'(out_mem_wr_addr), 32'h4F0);
    step();
    step();
    in_cpu_wr_en = 1'b0;
    reset = 1'b0;
    step();
    step();
    chk("mr_no_done", 32'(done_seen), 32'd0);
    chk("mr_beat2_not_written", 32'(dmem[12'h402]), 32'd0);
    chk("mr_cpu_store_dropped", 32'(dmem[12'h4F0]), 32'd0);
    clr(); dbase = 16'h90; in_dma_wr_word = 16'h90;
    request(1'b1, 12'h480, 4'd1);
    run_to_done(20);
    chk("mr_new_first_gnt", 32'(first_gnt - req_at), 32'd1);
    chk("mr_new_word0", 32'(dmem[12'h480]), 32'h90);
    chk("mr_new_word1", 32'(dmem[12'h481]), 32'h91);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
